// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, BUSY_IF, BUSY_DM)
//   owner_t     : which requester owns the access in flight
//   BE_ALL      : all-ones byte-enable source, sliced to the bus byte width
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  // Wide enough for any practical DATA_WIDTH; users take the low BE bits.
  localparam int BE_MAX_WIDTH = 128;
  localparam logic [BE_MAX_WIDTH-1:0] BE_ALL = '1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (IF fetch, DM load/store), the
// arbiter and the single-port memory.
//   slave  : arbiter view (takes requests + memory response, drives grants,
//            responses and the memory command)
//   master : environment view (requesters and memory), the mirror image
// Handshake: a requester raises req with a stable payload and keeps both
// stable until it sees gnt high in a cycle; the payload is captured on that
// clock edge. Responses come back as a one-cycle rvalid pulse. The memory
// command (mem_*) stays stable while mem_req is high until mem_ready=1.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int BE_WIDTH = DATA_WIDTH / 8;

  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_WIDTH-1:0] if_rdata;

  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [DATA_WIDTH-1:0] dm_wdata;
  logic [BE_WIDTH-1:0]   dm_be;
  logic                  dm_gnt;
  logic                  dm_rvalid;
  logic [DATA_WIDTH-1:0] dm_rdata;

  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [BE_WIDTH-1:0]   mem_be;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           mem_ready, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_be,
           mem_ready, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata,
           mem_req, mem_we, mem_addr, mem_wdata, mem_be
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection between fetch and data requests.
//   if_req, dm_req : pending requests
//   starved        : fetch has been passed over the maximum number of times
//   pick_if/pick_dm: one-hot (or zero) winner
// Data wins ties unless the fetch side is starved.
module mem_arb_pick (
  input  logic if_req,
  input  logic dm_req,
  input  logic starved,
  output logic pick_if,
  output logic pick_dm
);

  assign pick_if = if_req && (!dm_req || starved);
  assign pick_dm = dm_req && !pick_if;

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch (IF) and
// load/store (DM). One access in flight at a time; memory command registered.
//   clk       : rising-edge clock
//   rst       : asynchronous active-low reset
//   bus       : request/grant, response and memory signals (slave modport)
//   busy      : an access is in flight
//   dbg_state : current FSM state
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic            clk,
  input  logic            rst,
  mem_arbiter_if.slave    bus,
  output logic            busy,
  output arb_state_t      dbg_state
);

  localparam int BE_WIDTH  = DATA_WIDTH / 8;
  localparam int CNT_WIDTH = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(STARVE_LIMIT);

  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("mem_arbiter: STARVE_LIMIT must be at least 1");
  end

  arb_state_t            state;
  logic [CNT_WIDTH-1:0]  starve_cnt;
  owner_t                owner;
  logic                  window, done;
  logic                  pick_if, pick_dm, gnt_if, gnt_dm;

  logic                  mem_req_q, mem_we_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_wdata_q;
  logic [BE_WIDTH-1:0]   mem_be_q;
  logic                  if_rvalid_q, dm_rvalid_q;
  logic [DATA_WIDTH-1:0] if_rdata_q, dm_rdata_q;

  assign owner  = (state == BUSY_DM) ? OWN_DM : OWN_IF;
  // Completion of the access in flight; mem_ready while IDLE means nothing.
  assign done   = (state != IDLE) && bus.mem_ready;
  // A new access may start whenever the memory port is free by the next edge.
  assign window = (state == IDLE) || done;

  mem_arb_pick u_pick (
    .if_req  (bus.if_req),
    .dm_req  (bus.dm_req),
    .starved (starve_cnt == CNT_MAX),
    .pick_if (pick_if),
    .pick_dm (pick_dm)
  );

  // Grants are combinational but forced low while reset is held.
  assign gnt_if = rst && window && pick_if;
  assign gnt_dm = rst && window && pick_dm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      starve_cnt  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else if (gnt_dm) begin
      state       <= BUSY_DM;
      mem_req_q   <= 1'b1;
      mem_we_q    <= bus.dm_we;
      mem_addr_q  <= bus.dm_addr;
      mem_wdata_q <= bus.dm_wdata;
      mem_be_q    <= bus.dm_be;
      // Count DM wins that left a fetch waiting; saturate at the limit.
      if (!bus.if_req) begin
        starve_cnt <= '0;
      end else if (starve_cnt != CNT_MAX) begin
        starve_cnt <= starve_cnt + CNT_WIDTH'(1);
      end
    end else if (gnt_if) begin
      state       <= BUSY_IF;
      mem_req_q   <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= bus.if_addr;
      mem_wdata_q <= '0;
      mem_be_q    <= BE_ALL[BE_WIDTH-1:0];
      starve_cnt  <= '0;
    end else if (done) begin
      state     <= IDLE;
      mem_req_q <= 1'b0;
    end
  end

  // Response path: rdata registers only change on a read completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rvalid_q <= 1'b0;
      dm_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
    end else begin
      if_rvalid_q <= done && (owner == OWN_IF);
      dm_rvalid_q <= done && (owner == OWN_DM);
      if (done && (owner == OWN_IF)) begin
        if_rdata_q <= bus.mem_rdata;
      end
      if (done && (owner == OWN_DM) && !mem_we_q) begin
        dm_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.if_gnt    = gnt_if;
  assign bus.dm_gnt    = gnt_dm;
  assign bus.if_rvalid = if_rvalid_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rvalid = dm_rvalid_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: queued requesters, a memory model with a backing
// array, and a transaction-level reference of the arbitration rules.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } dm_req_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;
  arb_state_t dbg_state;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // ---------------- bench state ----------------
  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [31:0] phys_mem [0:255];  // contents the memory model serves
  logic [31:0] ref_mem  [0:255];  // contents in grant order (reference)

  logic [31:0] if_todo[$];
  dm_req_t     dm_todo[$];
  logic        if_on, dm_on;
  logic [31:0] if_cur;
  dm_req_t     dm_cur;

  logic        out_v;       // access in flight (reference view)
  dm_req_t     out_p;
  int          out_age;
  logic        prev_done;   // an access completed on the last edge
  logic [32:0] exp_q[$];    // {is_dm, expected rdata}
  logic [31:0] dm_last;
  int          starve;
  int          wait_cfg;    // <0: random memory latency, else fixed waits
  logic        ready_noise; // pulse mem_ready randomly while idle
  logic        g_log[$];    // 1 = IF grant, 0 = DM grant (as observed)
  int          if_gnt_cyc, dm_gnt_cyc, if_rv_cyc, dm_rv_cyc;

  // ---------------- scoreboard helpers ----------------
  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return {22'd0, 8'($urandom), 2'b00};
  endfunction

  function automatic dm_req_t rand_dm();
    dm_req_t r;
    r.we    = 1'($urandom_range(0, 1));
    r.addr  = rand_addr();
    r.wdata = $urandom;
    r.be    = 4'($urandom_range(1, 15));
    return r;
  endfunction

  // ---------------- one clock cycle of driving + checking ----------------
  task automatic step();
    logic        ready, win, exp_if, exp_dm;
    logic [32:0] e;
    logic [7:0]  idx;
    @(negedge clk);
    cyc++;
    if (bus.if_rvalid) if_rv_cyc = cyc;
    if (bus.dm_rvalid) dm_rv_cyc = cyc;

    // Responses: exactly one rvalid the cycle after a completion, else none.
    if (prev_done) begin
      if (exp_q.size() == 0) begin
        check_eq("resp_underflow", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check_eq("rvalid_pair", {bus.if_rvalid, bus.dm_rvalid}, {!e[32], e[32]});
        if (e[32]) check_eq("dm_rdata", bus.dm_rdata, e[31:0]);
        else       check_eq("if_rdata", bus.if_rdata, e[31:0]);
      end
    end else begin
      check_eq("rvalid_quiet", {bus.if_rvalid, bus.dm_rvalid}, 2'b00);
    end

    // Memory command mirrors the payload of the access in flight.
    check_eq("busy", busy, out_v);
    if (out_v) begin
      check_eq("mem_cmd", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be},
               {1'b1, out_p.we, out_p.addr, out_p.be});
      if (out_p.we) check_eq("mem_wdata", bus.mem_wdata, out_p.wdata);
    end else begin
      check_eq("mem_req_idle", bus.mem_req, 1'b0);
    end

    // Requesters present the next queued request once the last one is taken.
    if (!if_on && if_todo.size() > 0) begin if_cur = if_todo.pop_front(); if_on = 1'b1; end
    if (!dm_on && dm_todo.size() > 0) begin dm_cur = dm_todo.pop_front(); dm_on = 1'b1; end
    bus.if_req   = if_on;
    bus.if_addr  = if_on ? if_cur : $urandom;
    bus.dm_req   = dm_on;
    bus.dm_we    = dm_on ? dm_cur.we : 1'($urandom);
    bus.dm_addr  = dm_on ? dm_cur.addr : $urandom;
    bus.dm_wdata = dm_on ? dm_cur.wdata : $urandom;
    bus.dm_be    = dm_on ? dm_cur.be : 4'($urandom);

    // Memory model.
    if (out_v) begin
      out_age++;
      ready = (wait_cfg < 0) ? ($urandom_range(0, 2) == 0) : (out_age > wait_cfg);
    end else begin
      ready = ready_noise && ($urandom_range(0, 3) == 0);
    end
    idx = out_p.addr[9:2];
    bus.mem_ready = ready;
    bus.mem_rdata = (out_v && ready) ? phys_mem[idx] : $urandom;
    if (out_v && ready && out_p.we) phys_mem[idx] = merge(phys_mem[idx], out_p.wdata, out_p.be);

    #1;
    if (bus.if_gnt) if_gnt_cyc = cyc;
    if (bus.dm_gnt) dm_gnt_cyc = cyc;
    if (bus.if_gnt || bus.dm_gnt) g_log.push_back(bus.if_gnt);

    // Reference arbitration.
    win    = !out_v || ready;
    exp_if = win && if_on && (!dm_on || starve == LIMIT);
    exp_dm = win && dm_on && !exp_if;
    check_eq("gnt", {bus.if_gnt, bus.dm_gnt}, {exp_if, exp_dm});

    prev_done = out_v && ready;
    if (out_v && ready) out_v = 1'b0;
    if (exp_if) begin
      starve  = 0;
      out_v   = 1'b1;
      out_age = 0;
      out_p   = '{we: 1'b0, addr: if_cur, wdata: 32'd0, be: 4'hF};
      exp_q.push_back({1'b0, ref_mem[if_cur[9:2]]});
      if_on = 1'b0;
    end
    if (exp_dm) begin
      starve  = if_on ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
      out_v   = 1'b1;
      out_age = 0;
      out_p   = dm_cur;
      if (dm_cur.we) ref_mem[dm_cur.addr[9:2]] = merge(ref_mem[dm_cur.addr[9:2]], dm_cur.wdata, dm_cur.be);
      else           dm_last = ref_mem[dm_cur.addr[9:2]];
      exp_q.push_back({1'b1, dm_last});
      dm_on = 1'b0;
    end
  endtask

  // ---------------- reset (asynchronous, off the clock edge) ----------------
  task automatic do_reset();
    #3;
    rst = 1'b0;
    bus.if_req = 1'b1;
    bus.dm_req = 1'b1;
    #1;
    check_eq("rst_now", {bus.mem_req, busy, bus.if_gnt, bus.dm_gnt}, 4'b0000);
    bus.if_req = 1'b0;
    bus.dm_req = 1'b0;
    bus.mem_ready = 1'b0;
    out_v = 1'b0; prev_done = 1'b0; out_age = 0; starve = 0;
    if_on = 1'b0; dm_on = 1'b0; dm_last = '0;
    exp_q.delete(); if_todo.delete(); dm_todo.delete();
    repeat (2) @(negedge clk);
    check_eq("rst_mem", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_be}, 70'd0);
    check_eq("rst_resp", {bus.if_rvalid, bus.dm_rvalid, bus.if_rdata, bus.dm_rdata, busy}, 67'd0);
    check_eq("rst_state", dbg_state, IDLE);
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  task automatic drain();
    for (int i = 0; i < 80 && (out_v || prev_done || if_on || dm_on ||
         if_todo.size() > 0 || dm_todo.size() > 0); i++) step();
    check_eq("drain_done", {out_v, prev_done, if_on, dm_on}, 4'b0000);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [9:0] got;
    dm_req_t    w;
    for (int i = 0; i < 256; i++) begin
      phys_mem[i] = $urandom;
      ref_mem[i]  = phys_mem[i];
    end
    bus.if_req = 0; bus.if_addr = '0; bus.dm_req = 0; bus.dm_we = 0;
    bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
    bus.mem_ready = 0; bus.mem_rdata = '0;
    wait_cfg = 0; ready_noise = 1'b0; out_p = '0;
    if_gnt_cyc = 0; dm_gnt_cyc = 0; if_rv_cyc = 0; dm_rv_cyc = 0;

    do_reset();

    // Single fetch, one memory wait cycle.
    phys_mem[0] = 32'h0050_0093;
    ref_mem[0]  = 32'h0050_0093;
    wait_cfg = 1;
    if_todo.push_back(32'h0);
    repeat (6) step();
    check_eq("fetch_latency", if_rv_cyc - if_gnt_cyc, 3);
    check_eq("fetch_rdata", bus.if_rdata, 32'h0050_0093);

    // Contention with zero-wait memory.
    wait_cfg = 0;
    if_todo.push_back(rand_addr());
    dm_todo.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'd0, be: 4'hF});
    repeat (6) step();
    check_eq("cont_if_gnt", if_gnt_cyc - dm_gnt_cyc, 1);
    check_eq("cont_dm_rv", dm_rv_cyc - dm_gnt_cyc, 2);
    check_eq("cont_if_rv", if_rv_cyc - dm_gnt_cyc, 3);

    // Starvation bound with both requesters held high.
    g_log.delete();
    for (int i = 0; i < 10; i++) begin
      if_todo.push_back(rand_addr());
      dm_todo.push_back(rand_dm());
    end
    for (int i = 0; i < 40 && g_log.size() < 10; i++) step();
    got = '0;
    for (int i = 0; i < 10 && i < g_log.size(); i++) got[9-i] = g_log[i];
    check_eq("starve_seq", got, 10'b0000100001);
    drain();

    // Partial write, then read back the merged word.
    wait_cfg = 1;
    w = '{we: 1'b1, addr: 32'h104, wdata: 32'hDEAD_BEEF, be: 4'h3};
    dm_todo.push_back(w);
    repeat (5) step();
    dm_todo.push_back('{we: 1'b0, addr: 32'h104, wdata: 32'd0, be: 4'hF});
    drain();

    // Idle mem_ready pulses are ignored.
    ready_noise = 1'b1;
    repeat (8) step();
    check_eq("idle_state", dbg_state, IDLE);

    // Reset in the middle of a data access.
    wait_cfg = 1000;
    dm_todo.push_back(rand_dm());
    repeat (3) step();
    check_eq("mid_busy", busy, 1'b1);
    do_reset();
    repeat (6) step();
    wait_cfg = 0;
    if_todo.push_back(rand_addr());
    drain();

    // Randomized traffic with random latency and idle noise.
    wait_cfg = -1;
    for (int i = 0; i < 500; i++) begin
      if (if_todo.size() == 0 && $urandom_range(0, 99) < 50) if_todo.push_back(rand_addr());
      if (dm_todo.size() == 0 && $urandom_range(0, 99) < 55) dm_todo.push_back(rand_dm());
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
